// File: rtl/vn_update_sched.sv
// LDPC variable-node update scheduler: one shared external saturating adder
// first accumulates the posterior total, then streams total-minus-message extrinsics.
module vn_update_sched #(
    parameter int INT  = 8,
    parameter int FRAC = 8,
    parameter int DEG  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [INT+FRAC-1:0]   llr_ch,
    input  logic [INT+FRAC-1:0]   msg_in,
    input  logic                  msg_in_valid,
    output logic                  msg_in_ready,
    output logic [INT+FRAC-1:0]   add_a,
    output logic [INT+FRAC-1:0]   add_b,
    input  logic [INT+FRAC-1:0]   add_c,
    output logic [INT+FRAC-1:0]   ext_out,
    output logic                  ext_valid,
    input  logic                  ext_ready,
    output logic [INT+FRAC-1:0]   total,
    output logic                  hard_bit,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = INT + FRAC;
    localparam int CW = (DEG > 1) ? $clog2(DEG) : 1;
    localparam logic [CW-1:0] LAST    = CW'(DEG - 1);
    localparam logic [W-1:0]  POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  NEG_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, EXTR, DRAIN} state_t;

    state_t         state;
    logic [W-1:0]   acc;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   msg_buf [DEG];
    logic [W-1:0]   cur_msg;
    logic [W-1:0]   neg_msg;
    logic           issue;

    assign cur_msg = msg_buf[cnt];
    // Negating the most negative value would wrap, so it clamps to +max.
    assign neg_msg = (cur_msg == NEG_MIN) ? POS_MAX : (~cur_msg + 1'b1);
    assign issue   = !ext_valid || ext_ready;

    assign msg_in_ready = (state == ACCUM);
    assign busy         = (state != IDLE);

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state == ACCUM && msg_in_valid) begin
            add_a = acc;
            add_b = msg_in;
        end else if (state == EXTR) begin
            add_a = total;
            add_b = neg_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ext_out   <= '0;
            ext_valid <= 1'b0;
            total     <= '0;
            hard_bit  <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < DEG; i++) begin
                msg_buf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= llr_ch;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (msg_in_valid) begin
                        acc          <= add_c;
                        msg_buf[cnt] <= msg_in;
                        if (cnt == LAST) begin
                            total    <= add_c;
                            hard_bit <= add_c[W-1];
                            cnt      <= '0;
                            state    <= EXTR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                EXTR: begin
                    // Output register refills in the same cycle it is accepted.
                    if (issue) begin
                        ext_out   <= add_c;
                        ext_valid <= 1'b1;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (ext_valid && ext_ready) begin
                        ext_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vn_update_sched.sv
// Directed bench for vn_update_sched with a behavioural saturating adder,
// an expected-extrinsic queue and beat timing checks.
module tb_vn_update_sched;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  llr_ch = '0;
    logic [W-1:0]  msg_in = '0;
    logic          msg_in_valid = 1'b0;
    logic          msg_in_ready;
    logic [W-1:0]  add_a, add_b, add_c;
    logic [W-1:0]  ext_out;
    logic          ext_valid;
    logic          ext_ready = 1'b1;
    logic [W-1:0]  total;
    logic          hard_bit;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_cyc = 0;
    logic [W-1:0] exp_q[$];
    int           beat_q[$];
    logic [W-1:0] held;
    logic         held_v = 1'b0;
    logic [16:0]  sum;

    vn_update_sched dut (
        .clk(clk), .rst(rst), .start(start), .llr_ch(llr_ch),
        .msg_in(msg_in), .msg_in_valid(msg_in_valid), .msg_in_ready(msg_in_ready),
        .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .ext_out(ext_out), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .total(total), .hard_bit(hard_bit), .busy(busy), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // external saturating adder
    always_comb begin
        sum = {add_a[W-1], add_a} + {add_b[W-1], add_b};
        if (sum[16] != sum[15]) add_c = sum[16] ? 16'h8000 : 16'h7FFF;
        else                    add_c = sum[15:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard / monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (held_v) begin
                check("ext_stable", ext_out, held);
                check("ext_valid_held", ext_valid, 1);
            end
            held_v = ext_valid && !ext_ready;
            held   = ext_out;
            if (ext_valid && ext_ready) begin
                beat_q.push_back(cyc);
                if (exp_q.size() == 0) check("ext_unexpected", exp_q.size(), 1);
                else                   check("ext", ext_out, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_node(input logic [W-1:0] llr, input logic [W-1:0] m0, m1, m2,
                            input logic [W-1:0] tot, input logic hb,
                            input logic [W-1:0] e0, e1, e2,
                            input bit gaps, input bit bp, input bit thr);
        logic [W-1:0] m [3];
        int d0, k;
        m[0] = m0; m[1] = m1; m[2] = m2;
        exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
        beat_q.delete();
        d0 = done_cnt;
        start = 1'b1; llr_ch = llr;
        @(posedge clk); #1;
        start = 1'b0; llr_ch = 16'h5555;
        check("busy_accum", busy, 1);
        check("ready_accum", msg_in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            msg_in = m[i]; msg_in_valid = 1'b1;
            @(posedge clk); #1;
            msg_in_valid = 1'b0;
            if (i == 2) last_cyc = cyc;
            if (gaps && i < 2) begin
                start = 1'b1; llr_ch = 16'h1234; msg_in = 16'h7777;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        if (bp) begin
            @(posedge clk); #1;
            ext_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            ext_ready = 1'b1;
        end
        k = 0;
        while (done_cnt == d0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("done_count", done_cnt, d0 + 1);
        check("total", total, tot);
        check("hard_bit", hard_bit, hb);
        check("ext_left", exp_q.size(), 0);
        check("busy_after", busy, 0);
        check("done_pulse_len", done, 0);
        exp_q.delete();
        if (thr) begin
            check("beats", beat_q.size(), 3);
            if (beat_q.size() == 3) begin
                check("beat0_cyc", beat_q[0], last_cyc + 1);
                check("beat1_cyc", beat_q[1], last_cyc + 2);
                check("beat2_cyc", beat_q[2], last_cyc + 3);
                check("done_cyc", done_cyc, last_cyc + 4);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_total"}, total, 0);
        check({tag, "_hard"}, hard_bit, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ext_valid"}, ext_valid, 0);
        check({tag, "_ext_out"}, ext_out, 0);
        check({tag, "_ready"}, msg_in_ready, 0);
        check({tag, "_add"}, {add_a, add_b}, 0);
    endtask

    initial begin
        int d0;
        do_reset();
        check_reset_state("rst");

        // nominal with throughput timing
        run_node(16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0280, 1'b0,
                 16'h0080, 16'h0380, 16'h0200, 1'b0, 1'b0, 1'b1);
        // positive saturation
        run_node(16'h7000, 16'h7000, 16'h7000, 16'h0100, 16'h7FFF, 1'b0,
                 16'h0FFF, 16'h0FFF, 16'h7EFF, 1'b0, 1'b0, 1'b0);
        // negation corner
        run_node(16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b1,
                 16'hFFFF, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

        // reset in the middle of ACCUM
        d0 = done_cnt;
        start = 1'b1; llr_ch = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        msg_in = 16'h0200; msg_in_valid = 1'b1;
        @(posedge clk); #1;
        msg_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midrst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, d0);

        // nominal again with gaps, ignored starts and backpressure
        run_node(16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0280, 1'b0,
                 16'h0080, 16'h0380, 16'h0200, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vn_update_sched.md
Name: vn_update_sched

Overview:
Variable-node update scheduler for the LDPC decoder. It time-shares one external saturating adder of width INT+FRAC to do two things per node:
- accumulate the channel LLR plus DEG incoming check-to-variable messages into the posterior total;
- stream DEG extrinsic messages (total minus each incoming message) back to the check side.

It sits between the message memory/router and a single sat_adder instance that only this block drives.

Parameters:
INT, 8, integer bits of fixed-point LLR
FRAC, 8, fractional bits; W = INT+FRAC (local), two's complement
DEG, 3, messages per node, legal range 2..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a node; sampled only in IDLE
llr_ch  in  W  channel LLR, captured on accepted start
msg_in  in  W  incoming check message
msg_in_valid  in  1  msg_in valid
msg_in_ready  out  1  high only in ACCUM
add_a  out  W  shared adder operand a
add_b  out  W  shared adder operand b
add_c  in  W  shared adder saturated sum, combinational from add_a/add_b
ext_out  out  W  extrinsic message, registered
ext_valid  out  1  ext_out valid
ext_ready  in  1  downstream accepts ext_out
total  out  W  posterior LLR, registered
hard_bit  out  1  hard decision, registered
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at node completion

Behaviour:
- Reset: state=IDLE; acc, cnt and msg buffer cleared; ext_out=0, ext_valid=0, total=0, hard_bit=0, busy=0, done=0.
- Reset mid-operation: same as reset. Partial node is discarded. No done pulse.
- Adder contract: add_c = a+b, saturated to +max (0x7FFF for W=16) or -min (0x8000). add_a=add_b=0 when the block is not using the adder.
- IDLE:
  - start=1 -> acc<=llr_ch, cnt<=0, go to ACCUM.
  - start is ignored in every other state.
- ACCUM:
  - msg_in_ready=1.
  - Each cycle with msg_in_valid=1: add_a=acc, add_b=msg_in, acc<=add_c, buf[cnt]<=msg_in, cnt++.
  - On the DEG-th accept: total<=add_c, hard_bit<=add_c[W-1] (negative -> 1), cnt<=0, go to EXTR.
  - Gaps in msg_in_valid stall the state with no change.
- EXTR:
  - add_a=total, add_b=nsat(buf[cnt]).
  - nsat(x) = -x, except nsat(min) = +max.
  - Issue condition: (!ext_valid || ext_ready). On issue: ext_out<=add_c, ext_valid<=1, cnt++.
  - When not issuing, ext_out and ext_valid hold; ext_out stays stable under backpressure.
  - First ext_valid asserts 1 cycle after EXTR is entered.
  - Throughput is 1 message/cycle with ext_ready held high.
  - After issuing index DEG-1, go to DRAIN.
- DRAIN:
  - On ext_valid&&ext_ready: ext_valid<=0, done<=1 for one cycle, go to IDLE. busy drops in that same cycle.
- Output order: extrinsics leave in the same order as messages arrived.
- Saturation: extrinsic values are computed from the saturated total; no attempt is made to recover precision lost to saturation.
- total and hard_bit hold from end of ACCUM until the next accepted start.
- Simultaneous events:
  - A downstream accept and a new issue in the same cycle is legal and produces no bubble.
  - msg_in_valid outside ACCUM is ignored.

Test Plan:
- Nominal, W=16, DEG=3: llr_ch=0x0100; msgs 0x0200, 0xFF00, 0x0080 -> total=0x0280, hard_bit=0; ext = 0x0080, 0x0380, 0x0200 in order; done pulses once.
- Positive saturation: llr_ch=0x7000; msgs 0x7000, 0x7000, 0x0100 -> total=0x7FFF; ext = 0x0FFF, 0x0FFF, 0x7EFF.
- Negation corner: llr_ch=0x0000; msgs 0x8000, 0x0000, 0x0000 -> total=0x8000, hard_bit=1; ext = 0xFFFF, 0x8000, 0x8000.
- Backpressure and gaps: msg_in_valid toggled 1/0; ext_ready low 5 cycles mid-stream -> ext_out stable while low, no drop or duplicate, same values as the nominal test.
- Throughput: ext_ready tied high -> 3 ext_valid beats on consecutive cycles starting 1 cycle after EXTR entry; done on the cycle after the last accept.
- Control: start while busy -> ignored. rst asserted mid-ACCUM -> all outputs at reset values the next cycle, no done. A following start with the nominal data reproduces the nominal results.
